// File: rtl/mcs_bus_bridge.sv
// mcs_bus_bridge: MicroBlaze MCS IO bus to NUM_SLOTS MMIO slot bridge.
// Latency: strobe at T0 -> io_ready at T2 for a hit with immediate ack; T1 for a miss.
// Backpressure: one transfer in flight; strobes outside IDLE are dropped, slots stall via slot_ack.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   io_*                          MCS IO bus (strobes, byte address, write data, read data, ready)
//   slot_cs/rd/wr/addr/wr_data/be one-hot select plus 1-cycle strobe and latched command to slots
//   slot_rd_data, slot_ack        per-slot read data (slot i at [32*i +: 32]) and completion
//   err_clr, bus_err              sticky error flag and its clear
//
// Optional feature macro: BRIDGE_TIMEOUT_EN adds an ack timeout of TIMEOUT_CYCLES cycles.
module mcs_bus_bridge #(
  parameter logic [31:0] BRG_BASE       = 32'hC000_0000,
  parameter int          NUM_SLOTS      = 8,
  parameter int          REG_AW         = 5,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RD_DATA    = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    io_addr_strobe,
  input  logic                    io_read_strobe,
  input  logic                    io_write_strobe,
  input  logic [3:0]              io_byte_enable,
  input  logic [31:0]             io_address,
  input  logic [31:0]             io_write_data,
  output logic [31:0]             io_read_data,
  output logic                    io_ready,
  output logic [NUM_SLOTS-1:0]    slot_cs,
  output logic                    slot_rd,
  output logic                    slot_wr,
  output logic [REG_AW-1:0]       slot_addr,
  output logic [31:0]             slot_wr_data,
  output logic [3:0]              slot_be,
  input  logic [32*NUM_SLOTS-1:0] slot_rd_data,
  input  logic [NUM_SLOTS-1:0]    slot_ack,
  input  logic                    err_clr,
  output logic                    bus_err
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   idx_q, idx_d;
  logic [REG_AW-1:0]   reg_q, reg_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                rd_q, rd_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // The MCS raises io_addr_strobe together with the read/write strobe, so
  // only the direction strobes start a transfer; the low address byte-lane
  // bits and the unused upper address bits carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{io_addr_strobe, io_address};

  // Address decode of the incoming request
  logic              req;
  logic [SLOT_W-1:0] dec_idx;
  logic              base_hit;
  logic              idx_ok;
  logic              miss;

  assign req      = io_read_strobe | io_write_strobe;
  assign dec_idx  = io_address[2+REG_AW +: SLOT_W];
  assign base_hit = (io_address[31:24] == BRG_BASE[31:24]);
  // Only matters when NUM_SLOTS is not a power of two.
  assign idx_ok   = ({1'b0, dec_idx} < (SLOT_W+1)'(NUM_SLOTS));
  assign miss     = !base_hit || !idx_ok || (io_read_strobe && io_write_strobe);

  // Ack and read data of the latched slot only; other slots' acks are ignored.
  logic        ack_sel;
  logic [31:0] sel_rd_data;

  always_comb begin
    ack_sel     = 1'b0;
    sel_rd_data = 32'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx_q == SLOT_W'(i)) begin
        ack_sel     = slot_ack[i];
        sel_rd_data = slot_rd_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    // A set later in this block overrides the clear in the same cycle.
    err_d   = err_q & ~err_clr;
`ifdef BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef BRIDGE_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (req) begin
          idx_d   = dec_idx;
          reg_d   = io_address[2 +: REG_AW];
          wdata_d = io_write_data;
          be_d    = io_byte_enable;
          rd_d    = io_read_strobe;
          if (miss) begin
            state_d = RESP;
            rdata_d = ERR_RD_DATA;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end

      ACCESS, WAIT: begin
        if (ack_sel) begin
          state_d = RESP;
          rdata_d = rd_q ? sel_rd_data : 32'd0;
`ifdef BRIDGE_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // ACCESS is window cycle 1 with cnt_q==0, so this fires on
          // window cycle TIMEOUT_CYCLES after its ack check failed.
          state_d = RESP;
          rdata_d = ERR_RD_DATA;
          err_d   = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q + 1'b1;
`else
        end else begin
          state_d = WAIT;
`endif
        end
      end

      RESP: begin
        state_d = IDLE;
        rdata_d = 32'd0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Slot-side outputs decode straight from state so an asserted reset drops
  // them without waiting for a clock edge.
  logic in_xfer;
  assign in_xfer      = (state_q == ACCESS) || (state_q == WAIT);
  assign slot_cs      = in_xfer ? (NUM_SLOTS'(1) << idx_q) : '0;
  assign slot_rd      = (state_q == ACCESS) &&  rd_q;
  assign slot_wr      = (state_q == ACCESS) && !rd_q;
  assign slot_addr    = reg_q;
  assign slot_wr_data = wdata_q;
  assign slot_be      = be_q;
  assign io_ready     = (state_q == RESP);
  assign io_read_data = rdata_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_mcs_bus_bridge.sv
// tb_mcs_bus_bridge: self-checking bench for mcs_bus_bridge.
// Expected responses (data and completion cycle) are queued when a request is
// driven and compared by a monitor when io_ready is seen.
module tb_mcs_bus_bridge;

  localparam int NS  = 8;
  localparam int RAW = 6;   // makes 0xC000_0104 decode as slot 1, register 1
  localparam int TOC = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [3:0]    io_byte_enable;
  logic [31:0]   io_address, io_write_data, io_read_data;
  logic          io_ready;
  logic [NS-1:0] slot_cs;
  logic          slot_rd, slot_wr;
  logic [RAW-1:0] slot_addr;
  logic [31:0]   slot_wr_data;
  logic [3:0]    slot_be;
  logic [32*NS-1:0] slot_rd_data;
  logic [NS-1:0] slot_ack;
  logic          err_clr, bus_err;

  mcs_bus_bridge #(
    .BRG_BASE(32'hC000_0000), .NUM_SLOTS(NS), .REG_AW(RAW),
    .TIMEOUT_CYCLES(TOC), .ERR_RD_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
    .io_address(io_address), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
    .slot_addr(slot_addr), .slot_wr_data(slot_wr_data), .slot_be(slot_be),
    .slot_rd_data(slot_rd_data), .slot_ack(slot_ack),
    .err_clr(err_clr), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: compare every io_ready pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && io_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", io_read_data, e.data);
        check("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] mk_addr(input int slot, input int rg);
    return 32'hC000_0000 | (32'(slot) << (2 + RAW)) | (32'(rg) << 2);
  endfunction

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("ready_wait_expired", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("bus_err_cleared", {31'd0, bus_err}, 32'd0);
  endtask

  // One transfer. slot < 0 means the request is expected to miss.
  // ack_dly: cycles after ACCESS when the slot acks. noise: another slot
  // that holds its ack high until the real ack (-1 for none).
  task automatic do_txn(input bit rd, input bit both, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int slot, input int ack_dly, input logic [31:0] rdval,
                        input int noise, input bit clr);
    exp_t e;
    logic [NS-1:0] nmask;
    nmask = (noise >= 0) ? (NS'(1) << noise) : '0;
    @(negedge clk);
    if (slot >= 0) slot_rd_data[32*slot +: 32] = rdval;
    if (noise >= 0) slot_rd_data[32*noise +: 32] = 32'h5555_5555;
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd | both;
    io_write_strobe = ~rd | both;
    io_address      = addr;
    io_write_data   = wdata;
    io_byte_enable  = be;
    err_clr         = clr;
    e.data = (slot < 0) ? 32'hDEAD_BEEF : (rd ? rdval : 32'd0);
    e.cyc  = cyc + ((slot < 0) ? 1 : 2 + ack_dly);
    exp_q.push_back(e);
    @(negedge clk);
    io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
    err_clr = 1'b0;
    if (slot < 0) begin
      check("miss_bus_err", {31'd0, bus_err}, 32'd1);
    end else begin
      check("acc_cs", 32'(slot_cs), 32'(NS'(1) << slot));
      check("acc_rd", {31'd0, slot_rd}, {31'd0, rd});
      check("acc_wr", {31'd0, slot_wr}, {31'd0, ~rd});
      check("acc_addr", 32'(slot_addr), 32'(addr[2 +: RAW]));
      if (!rd) begin
        check("acc_wdata", slot_wr_data, wdata);
        check("acc_be", 32'(slot_be), 32'(be));
      end
      slot_ack = nmask | ((ack_dly == 0) ? (NS'(1) << slot) : '0);
      for (int d = 1; d <= ack_dly; d++) begin
        @(negedge clk);
        check("wait_cs", 32'(slot_cs), 32'(NS'(1) << slot));
        check("wait_strobes", {30'd0, slot_rd, slot_wr}, 32'd0);
        slot_ack = (d == ack_dly) ? (NS'(1) << slot) : nmask;
      end
      @(negedge clk);
      slot_ack = '0;
    end
    wait_done(60);
  endtask

  initial begin
    reset_n = 1'b0;
    io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
    io_byte_enable = 4'h0; io_address = 32'd0; io_write_data = 32'd0;
    slot_rd_data = '0; slot_ack = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, io_ready}, 32'd0);
    check("rst_rdata", io_read_data, 32'd0);
    check("rst_cs", 32'(slot_cs), 32'd0);
    check("rst_rdwr", {30'd0, slot_rd, slot_wr}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_addr", 32'(slot_addr), 32'd0);
    reset_n = 1'b1;

    // Write slot 1 reg 1, acked in ACCESS -> io_ready at T2
    do_txn(1'b0, 1'b0, 32'hC000_0104, 32'hA5A5_0001, 4'hF, 1, 0, 32'd0, -1, 1'b0);
    // Read slot 3, ack 5 cycles after ACCESS -> io_ready at T7
    do_txn(1'b1, 1'b0, mk_addr(3, 7), 32'd0, 4'hF, 3, 5, 32'h1234_5678, -1, 1'b0);
    // Base miss -> io_ready at T1 with error data
    do_txn(1'b1, 1'b0, 32'h8000_0000, 32'd0, 4'hF, -1, 0, 32'd0, -1, 1'b0);
    @(negedge clk);
    check("rdata_cleared", io_read_data, 32'd0);
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);
    // Both strobes -> miss; err_clr in the same cycle loses to the set
    do_txn(1'b1, 1'b1, mk_addr(2, 0), 32'd0, 4'hF, -1, 0, 32'd0, -1, 1'b1);
    pulse_clr();
    // Top slot / top register, partial byte enables
    do_txn(1'b0, 1'b0, mk_addr(7, 63), 32'hCAFE_F00D, 4'h3, 7, 2, 32'd0, -1, 1'b0);
    // Slot 2 acking during slot 5 access must be ignored
    do_txn(1'b1, 1'b0, mk_addr(5, 4), 32'd0, 4'hF, 5, 3, 32'h0BAD_F00D, 2, 1'b0);
    do_txn(1'b1, 1'b0, mk_addr(0, 0), 32'd0, 4'hF, 0, 0, 32'h0000_0001, -1, 1'b0);
    check("no_err_after_hits", {31'd0, bus_err}, 32'd0);

    // Slot 6 never acks
    begin
      exp_t e;
      @(negedge clk);
      io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_address = mk_addr(6, 2);
`ifdef BRIDGE_TIMEOUT_EN
      e.data = 32'hDEAD_BEEF; e.cyc = cyc + TOC + 1;
      exp_q.push_back(e);
      @(negedge clk);
      io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
      wait_done(60);
      check("to_bus_err", {31'd0, bus_err}, 32'd1);
      check("to_cs_dropped", 32'(slot_cs), 32'd0);
      pulse_clr();
`else
      @(negedge clk);
      io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
      repeat (40) @(negedge clk);
      check("noto_no_ready", {31'd0, io_ready}, 32'd0);
      check("noto_cs_held", 32'(slot_cs), 32'h40);
      slot_rd_data[32*6 +: 32] = 32'h6666_0006;
      slot_ack = 8'h40;
      e.data = 32'h6666_0006; e.cyc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      slot_ack = '0;
      wait_done(20);
      check("noto_bus_err", {31'd0, bus_err}, 32'd0);
`endif
    end

    // Reset asserted while waiting on slot 4
    @(negedge clk);
    io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_address = mk_addr(4, 9);
    @(negedge clk);
    io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_cs", 32'(slot_cs), 32'h10);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_cs", 32'(slot_cs), 32'd0);
    check("midrst_ready", {31'd0, io_ready}, 32'd0);
    check("midrst_addr", 32'(slot_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(1'b1, 1'b0, mk_addr(4, 9), 32'd0, 4'hF, 4, 1, 32'h4444_0004, -1, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
